// File: rtl/keypad_scan_encoder.sv
// keypad_scan_encoder: column-strobed matrix keypad scanner with frame-level debounce,
// key index / BCD encoding and a valid/ready record output with sticky overrun.
module keypad_scan_encoder #(
   parameter int ROWS            = 4,
   parameter int COLS            = 3,
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_FRAMES = 3,
   parameter int IDX_W           = $clog2(ROWS*COLS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [ROWS-1:0]  row_in,
   output logic [COLS-1:0]  col_drive,
   output logic [IDX_W-1:0] key_index,
   output logic [3:0]       key_bcd,
   output logic             key_valid,
   input  logic             key_ready,
   output logic             key_held,
   output logic             overrun
);
   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int CW    = $clog2(COLS);
   localparam int DB_W  = $clog2(DEBOUNCE_FRAMES + 1);

   typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} state_t;

   state_t           r_state;
   logic [ROWS-1:0]  r_sync1, r_sync2;
   logic [DIV_W-1:0] r_div;
   logic [CW-1:0]    r_col;
   logic [1:0]       r_acc_n, r_res_n;
   logic [IDX_W-1:0] r_acc_k, r_res_k, r_cand;
   logic             r_frame;
   logic [DB_W-1:0]  r_cnt;

   logic             w_last, w_frame_end, w_none, w_single, w_press, w_done, w_accept, w_consume;
   logic [1:0]       w_row_n, w_tot;
   logic [2:0]       w_sum;
   logic [IDX_W-1:0] w_row_k, w_key;
   logic [DB_W-1:0]  w_cnt_nxt;
   logic [3:0]       w_phone, w_plain, w_bcd;

   // bit count of the sampled column, saturating at 2 (0 / 1 / many)
   always_comb begin
      w_row_n = 2'd0;
      w_row_k = '0;
      for (int r = 0; r < ROWS; r++)
         if (r_sync2[r]) begin
            w_row_k = IDX_W'(r*COLS) + IDX_W'(r_col);
            w_row_n = (w_row_n == 2'd0) ? 2'd1 : 2'd2;
         end
   end

   assign w_last      = r_div == DIV_W'(SCAN_DIV - 1);
   assign w_frame_end = w_last && r_col == CW'(COLS - 1);
   assign w_sum       = {1'b0, r_acc_n} + {1'b0, w_row_n};
   assign w_tot       = (w_sum > 3'd2) ? 2'd2 : w_sum[1:0];
   assign w_key       = (r_acc_n == 2'd0) ? w_row_k : r_acc_k;

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_sync1   <= '0;
         r_sync2   <= '0;
         r_div     <= '0;
         r_col     <= '0;
         col_drive <= COLS'(1);
         r_acc_n   <= 2'd0;
         r_acc_k   <= '0;
         r_frame   <= 1'b0;
         r_res_n   <= 2'd0;
         r_res_k   <= '0;
      end else begin
         r_sync1 <= row_in;
         r_sync2 <= r_sync1;
         r_div   <= w_last ? '0 : r_div + DIV_W'(1);
         r_frame <= w_frame_end;
         if (w_last) begin
            r_col     <= w_frame_end ? '0 : r_col + CW'(1);
            col_drive <= w_frame_end ? COLS'(1) : col_drive << 1;
            r_acc_n   <= w_frame_end ? 2'd0 : w_tot;
            r_acc_k   <= (r_acc_n == 2'd0) ? w_row_k : r_acc_k;
            if (w_frame_end) begin
               r_res_n <= w_tot;
               r_res_k <= w_key;
            end
         end
      end

   assign w_phone = (int'(r_res_k) < 9) ? 4'(int'(r_res_k) + 1) :
                    (int'(r_res_k) == 9) ? 4'hA : (int'(r_res_k) == 10) ? 4'h0 : 4'hB;
   assign w_plain = (int'(r_res_k) < 10) ? 4'(r_res_k) : 4'hF;
   assign w_bcd   = (ROWS == 4 && COLS == 3) ? w_phone : w_plain;

   // frame results feed the debouncer; MULTI counts as neither a press nor a release
   assign w_none    = r_res_n == 2'd0;
   assign w_single  = r_res_n == 2'd1;
   assign w_press   = w_single && (r_state == IDLE || r_res_k == r_cand);
   assign w_cnt_nxt = (r_state == IDLE || r_state == HELD) ? DB_W'(1) : r_cnt + DB_W'(1);
   assign w_done    = w_cnt_nxt == DB_W'(DEBOUNCE_FRAMES);
   assign w_accept  = r_frame && (r_state == IDLE || r_state == PRESS_CHK) && w_press && w_done;
   assign w_consume = key_valid && key_ready;

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_cand    <= '0;
         key_held  <= 1'b0;
         key_valid <= 1'b0;
         key_index <= '0;
         key_bcd   <= 4'd0;
         overrun   <= 1'b0;
      end else begin
         if (r_frame)
            case (r_state)
               IDLE, PRESS_CHK: begin
                  r_state  <= !w_press ? IDLE : w_done ? HELD : PRESS_CHK;
                  r_cnt    <= (w_press && !w_done) ? w_cnt_nxt : '0;
                  key_held <= w_press && w_done;
                  if (r_state == IDLE)
                     r_cand <= r_res_k;
               end
               HELD, RELEASE_CHK: begin
                  r_state  <= !w_none ? HELD : w_done ? IDLE : RELEASE_CHK;
                  r_cnt    <= (w_none && !w_done) ? w_cnt_nxt : '0;
                  key_held <= !(w_none && w_done);
               end
               default: r_state <= IDLE;
            endcase
         // a consume in the accept cycle frees the slot before the new record lands
         if (w_accept && (!key_valid || w_consume)) begin
            key_index <= r_res_k;
            key_bcd   <= w_bcd;
            key_valid <= 1'b1;
         end else begin
            if (w_consume)
               key_valid <= 1'b0;
            if (w_accept)
               overrun <= 1'b1;
         end
      end
endmodule
